// File: rtl/snake_pkg.sv
// Purpose : shared phase encodings for the snake datapath sequencer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Imported by game_scheduler, tick_timer, key_control and the debug/VGA overlay.
package snake_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_RESTART   = 3'd1,
    PH_WAIT_TICK = 3'd2,
    PH_MOVE      = 3'd3,
    PH_FIELD     = 3'd4,
    PH_CHECK     = 3'd5,
    PH_APPLE     = 3'd6,
    PH_OVER      = 3'd7
  } phase_e;

  // Stages that wait on a datapath done strobe and are guarded by the watchdog.
  function automatic logic is_busy(input phase_e ph);
    return (ph == PH_MOVE) || (ph == PH_FIELD) || (ph == PH_CHECK) || (ph == PH_APPLE);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Purpose : per-stage cycle counter; flags a stage that has run TIMEOUT_CLK cycles.
// Latency : expired is combinational on the counter, high in the TIMEOUT_CLK-th enabled cycle.
// Backpr. : none; clr has priority over counting.
// Ports   : clk, rst (sync, active-high), clr (restart count), en (count this cycle),
//           expired (count has reached TIMEOUT_CLK-1 while enabled).
module stage_watchdog #(
  parameter int TIMEOUT_CLK = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CLK);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLK - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/game_scheduler.sv
// Purpose : sequences each game tick as move -> field -> check -> optional apple;
//           owns start/restart, pause, score, dropped-tick count and stage watchdog.
// Latency : every output registered; step pulses appear 1 cycle after the causing strobe.
// Backpr. : none; ticks arriving while a step is in flight are dropped and counted.
// Ports   : tick/start_key/pause_key from timer and keys; *_done + dead/grow from datapath;
//           restart/move_step/field_step/check_req pulses, apple_req level, score,
//           tick_overrun, paused, stage_err (sticky), phase (state code).
module game_scheduler
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CLK = 4096,
  parameter int SCORE_W     = 16,
  parameter int OVR_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_key,
  input  logic               pause_key,
  input  logic               move_done,
  input  logic               field_done,
  input  logic               apple_done,
  input  logic               check_done,
  input  logic               dead,
  input  logic               grow,
  output logic               restart,
  output logic               move_step,
  output logic               field_step,
  output logic               check_req,
  output logic               apple_req,
  output logic [SCORE_W-1:0] score,
  output logic [OVR_W-1:0]   tick_overrun,
  output logic               paused,
  output logic               stage_err,
  output logic [PHASE_W-1:0] phase
);

  phase_e             r_state;
  logic               r_restart;
  logic               r_move_step;
  logic               r_field_step;
  logic               r_check_req;
  logic               r_apple_req;
  logic [SCORE_W-1:0] r_score;
  logic [OVR_W-1:0]   r_ovr;
  logic               r_paused;
  logic               r_stage_err;

  phase_e w_state_nxt;
  logic   w_timeout;
  logic   w_expired;
  logic   w_wd_clr;
  logic   w_grow_ev;
  logic   w_drop;
  logic   w_pause_tog;

  // Counter restarts whenever a new state is entered; a fresh RESTART also
  // re-arms it even though RESTART -> RESTART is not a state change.
  assign w_wd_clr = (w_state_nxt != r_state) || start_key;

  stage_watchdog #(
    .TIMEOUT_CLK(TIMEOUT_CLK)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_wd_clr),
    .en     (is_busy(r_state)),
    .expired(w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    if (start_key) begin
      w_state_nxt = PH_RESTART;
    end else if (w_expired) begin
      w_state_nxt = PH_OVER;
      w_timeout   = 1'b1;
    end else begin
      case (r_state)
        PH_RESTART:   w_state_nxt = PH_APPLE;
        PH_WAIT_TICK: if (tick && !r_paused) w_state_nxt = PH_MOVE;
        PH_MOVE:      if (move_done)  w_state_nxt = PH_FIELD;
        PH_FIELD:     if (field_done) w_state_nxt = PH_CHECK;
        PH_CHECK: begin
          if (check_done) begin
            // dead outranks grow: a fatal move never scores
            if (dead)      w_state_nxt = PH_OVER;
            else if (grow) w_state_nxt = PH_APPLE;
            else           w_state_nxt = PH_WAIT_TICK;
          end
        end
        PH_APPLE:     if (apple_done) w_state_nxt = PH_WAIT_TICK;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  assign w_grow_ev   = !start_key && !w_expired && (r_state == PH_CHECK)
                       && check_done && !dead && grow;
  assign w_drop      = tick && (is_busy(r_state) || (r_state == PH_RESTART));
  assign w_pause_tog = pause_key && (is_busy(r_state) || (r_state == PH_WAIT_TICK));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= PH_IDLE;
      r_restart    <= 1'b0;
      r_move_step  <= 1'b0;
      r_field_step <= 1'b0;
      r_check_req  <= 1'b0;
      r_apple_req  <= 1'b0;
      r_score      <= '0;
      r_ovr        <= '0;
      r_paused     <= 1'b0;
      r_stage_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Each RESTART cycle is itself a fresh restart request
      r_restart    <= (w_state_nxt == PH_RESTART);
      r_move_step  <= (w_state_nxt == PH_MOVE)  && (r_state != PH_MOVE);
      r_field_step <= (w_state_nxt == PH_FIELD) && (r_state != PH_FIELD);
      r_check_req  <= (w_state_nxt == PH_CHECK) && (r_state != PH_CHECK);
      r_apple_req  <= (w_state_nxt == PH_APPLE);
      if (start_key) begin
        // Cleared on the way into RESTART so the restart cycle already shows zeros
        r_score     <= '0;
        r_ovr       <= '0;
        r_paused    <= 1'b0;
        r_stage_err <= 1'b0;
      end else begin
        if (w_timeout) r_stage_err <= 1'b1;
        if (w_grow_ev && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
        if (w_drop && (r_ovr != '1))      r_ovr   <= r_ovr + OVR_W'(1);
        if (w_pause_tog)                  r_paused <= !r_paused;
      end
    end
  end

  assign restart      = r_restart;
  assign move_step    = r_move_step;
  assign field_step   = r_field_step;
  assign check_req    = r_check_req;
  assign apple_req    = r_apple_req;
  assign score        = r_score;
  assign tick_overrun = r_ovr;
  assign paused       = r_paused;
  assign stage_err    = r_stage_err;
  assign phase        = r_state;

endmodule

// File: tb/tb_game_scheduler.sv
// Purpose : directed self-checking bench for game_scheduler (SCORE_W=2, TIMEOUT_CLK=16).
// Latency : inputs change 1ns after posedge, outputs sampled at the same point.
// Backpr. : n/a.
module tb_game_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, start_key, pause_key;
  logic       move_done, field_done, apple_done, check_done, dead, grow;
  logic       restart, move_step, field_step, check_req, apple_req;
  logic [1:0] score;
  logic [7:0] tick_overrun;
  logic       paused, stage_err;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_scheduler #(
    .TIMEOUT_CLK(16),
    .SCORE_W    (2),
    .OVR_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start_key   (start_key),
    .pause_key   (pause_key),
    .move_done   (move_done),
    .field_done  (field_done),
    .apple_done  (apple_done),
    .check_done  (check_done),
    .dead        (dead),
    .grow        (grow),
    .restart     (restart),
    .move_step   (move_step),
    .field_step  (field_step),
    .check_req   (check_req),
    .apple_req   (apple_req),
    .score       (score),
    .tick_overrun(tick_overrun),
    .paused      (paused),
    .stage_err   (stage_err),
    .phase       (phase)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full game step from WAIT_TICK up to the verdict edge.
  task automatic run_step(input logic dead_v, input logic grow_v);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("step_move_phase", phase, 3);
    chk("step_move_pulse", move_step, 1);
    move_done = 1'b1; cyc(); move_done = 1'b0;
    chk("step_field_phase", phase, 4);
    chk("step_field_pulse", field_step, 1);
    chk("step_move_pulse_off", move_step, 0);
    field_done = 1'b1; cyc(); field_done = 1'b0;
    chk("step_check_phase", phase, 5);
    chk("step_check_req", check_req, 1);
    check_done = 1'b1; dead = dead_v; grow = grow_v;
    cyc();
    check_done = 1'b0; dead = 1'b0; grow = 1'b0;
  endtask

  task automatic finish_apple();
    apple_done = 1'b1; cyc(); apple_done = 1'b0;
    chk("apple_exit_phase", phase, 2);
    chk("apple_exit_req", apple_req, 0);
  endtask

  initial begin
    rst = 1'b1;
    {tick, start_key, pause_key, move_done, field_done, apple_done, check_done, dead, grow} = '0;

    // Reset
    cyc(); cyc();
    chk("rst_phase", phase, 0);
    chk("rst_pulses", {restart, move_step, field_step, check_req, apple_req}, 0);
    chk("rst_score", score, 0);
    chk("rst_stage_err", stage_err, 0);
    rst = 1'b0;
    cyc();
    chk("idle_phase", phase, 0);

    // Start: RESTART -> APPLE -> WAIT_TICK, apple_done 3 cycles after start_key
    start_key = 1'b1; cyc(); start_key = 1'b0;
    chk("start_phase", phase, 1);
    chk("start_restart", restart, 1);
    cyc();
    chk("start_apple_phase", phase, 6);
    chk("start_restart_off", restart, 0);
    cyc();
    chk("start_apple_hold", apple_req, 1);
    finish_apple();

    // Plain step, no grow
    run_step(1'b0, 1'b0);
    chk("nogrow_phase", phase, 2);
    chk("nogrow_score", score, 0);

    // Grow: apple_req held until apple_done
    run_step(1'b0, 1'b1);
    chk("grow1_phase", phase, 6);
    chk("grow1_score", score, 1);
    chk("grow1_apple_req", apple_req, 1);
    cyc();
    chk("grow1_apple_hold", apple_req, 1);
    finish_apple();
    run_step(1'b0, 1'b1); chk("grow2_score", score, 2); finish_apple();
    run_step(1'b0, 1'b1); chk("grow3_score", score, 3); finish_apple();
    run_step(1'b0, 1'b1); chk("grow4_saturate", score, 3); finish_apple();

    // Done strobe outside its own state is ignored
    field_done = 1'b1; cyc(); field_done = 1'b0;
    chk("stray_done_phase", phase, 2);

    // Dead beats grow; OVER ignores ticks and strobes
    run_step(1'b1, 1'b1);
    chk("dead_phase", phase, 7);
    chk("dead_score", score, 3);
    tick = 1'b1; move_done = 1'b1; cyc(); tick = 1'b0; move_done = 1'b0;
    chk("over_tick_phase", phase, 7);
    chk("over_tick_no_move", move_step, 0);
    chk("over_tick_not_counted", tick_overrun, 0);
    start_key = 1'b1; cyc(); start_key = 1'b0;
    chk("restart_pulse", restart, 1);
    chk("restart_score", score, 0);
    cyc();
    finish_apple();

    // Pause
    pause_key = 1'b1; cyc(); pause_key = 1'b0;
    chk("pause_on", paused, 1);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk("paused_tick_phase", phase, 2);
      chk("paused_tick_no_move", move_step, 0);
    end
    chk("paused_overrun", tick_overrun, 0);
    pause_key = 1'b1; cyc(); pause_key = 1'b0;
    chk("pause_off", paused, 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("unpause_move", move_step, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("busy_tick_overrun", tick_overrun, 1);
    chk("busy_tick_phase", phase, 3);
    move_done = 1'b1; cyc(); move_done = 1'b0;
    field_done = 1'b1; cyc(); field_done = 1'b0;
    check_done = 1'b1; cyc(); check_done = 1'b0;
    chk("pause_step_done", phase, 2);

    // Watchdog: withhold move_done
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("wd_enter_move", phase, 3);
    repeat (15) cyc();
    chk("wd_cycle16_phase", phase, 3);
    chk("wd_cycle16_err", stage_err, 0);
    cyc();
    chk("wd_over_phase", phase, 7);
    chk("wd_stage_err", stage_err, 1);
    start_key = 1'b1; cyc(); start_key = 1'b0;
    chk("wd_restart_err_clr", stage_err, 0);
    chk("wd_restart_ovr_clr", tick_overrun, 0);
    cyc();
    chk("mid_apple_phase", phase, 6);

    // Reset mid-operation
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst_phase", phase, 0);
    chk("midrst_pulses", {restart, move_step, field_step, check_req, apple_req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
